// File: rtl/iterative_alu.sv
`timescale 1ns/1ps
// Iterative ALU: single-cycle logic/arith ops, shifts done one bit per cycle.
// Results are held in DONE until the consumer takes them. There is no overlap:
// a new request is only accepted after the previous result has been consumed.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a request, in_ready = 1
// SHIFT | shifting accumulator one bit per cycle, counter counts down
// DONE  | result valid on ALUResult/Zero, waiting for out_ready
module iterative_alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_EQ  = 4'b1000;
  localparam logic [3:0] OP_SRA = 4'b1001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state_q;
  state_t                  state_nxt;
  logic [DATA_WIDTH-1:0]   acc_q;
  logic [DATA_WIDTH-1:0]   acc_step;
  logic [4:0]              cnt_q;
  logic [3:0]              kind_q;
  logic [DATA_WIDTH-1:0]   result_q;
  logic [DATA_WIDTH-1:0]   single_res;
  logic                    accept;
  logic                    req_is_shift;
  logic [4:0]              req_shamt;
  logic                    shift_last;

  assign accept       = in_valid && (state_q == IDLE);
  assign req_shamt    = SrcB[4:0];
  assign req_is_shift = (Operation == OP_SLL) || (Operation == OP_SRL) ||
                        (Operation == OP_SRA);
  // Terminal count: the shift performed while the counter reads 1 is the last one.
  assign shift_last   = (cnt_q == 5'd1);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign ALUResult = result_q;
  assign Zero      = (result_q == '0);

  // Single-cycle result for every non-shift opcode; unsupported codes give 0.
  always_comb begin
    single_res = '0;
    case (Operation)
      OP_AND: single_res = SrcA & SrcB;
      OP_OR:  single_res = SrcA | SrcB;
      OP_ADD: single_res = SrcA + SrcB;
      OP_SUB: single_res = SrcA - SrcB;
      OP_XOR: single_res = SrcA ^ SrcB;
      OP_SLT: single_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_EQ:  single_res = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
      default: single_res = '0;
    endcase
  end

  // One-bit shift of the accumulator according to the latched shift kind.
  always_comb begin
    acc_step = acc_q;
    case (kind_q)
      OP_SLL:  acc_step = {acc_q[DATA_WIDTH-2:0], 1'b0};
      OP_SRL:  acc_step = {1'b0, acc_q[DATA_WIDTH-1:1]};
      OP_SRA:  acc_step = {acc_q[DATA_WIDTH-1], acc_q[DATA_WIDTH-1:1]};
      default: acc_step = acc_q;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  // Next-state logic; a zero shift amount skips SHIFT entirely.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (req_is_shift && (req_shamt != 5'd0)) state_nxt = SHIFT;
          else                                     state_nxt = DONE;
        end
      end
      SHIFT: begin
        if (shift_last) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch request at accept, iterate shifts, capture the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      kind_q   <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_q  <= SrcA;
            kind_q <= Operation;
            if (req_is_shift) begin
              cnt_q <= req_shamt;
              if (req_shamt == 5'd0) result_q <= SrcA;
            end else begin
              cnt_q    <= '0;
              result_q <= single_res;
            end
          end
        end
        SHIFT: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q - 5'd1;
          if (shift_last) result_q <= acc_step;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/iterative_alu.md
ITERATIVE_ALU -- requirements
Module: iterative_alu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width; legal value 32 only (shift amount is 5 bits).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 SHALL have port in_valid  input  1  a request (Operation, SrcA, SrcB) is presented.
REQ-005 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-006 SHALL have port Operation  input  4  ALU operation code from the ALU controller.
REQ-007 SHALL have port SrcA  input  32  first operand.
REQ-008 SHALL have port SrcB  input  32  second operand; bits [4:0] are the shift amount for shift ops.
REQ-009 SHALL have port out_valid  output  1  ALUResult/Zero hold a completed result.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-011 SHALL have port ALUResult  output  32  registered result.
REQ-012 SHALL have port Zero  output  1  high when ALUResult == 0.

Function
REQ-013 SHALL decode Operation: 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SLT (signed), 1000 EQ, 1001 SRA; 1010-1111 unsupported.
REQ-014 SHALL compute ADD/SUB modulo 2^32, no overflow indication; SLT result 1 if $signed(SrcA) < $signed(SrcB) else 0; EQ result 1 if SrcA == SrcB else 0; unsupported codes result 0.
REQ-015 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-016 SHALL drive in_ready = 1 only in IDLE; accept occurs when in_valid && in_ready; in_valid is ignored in SHIFT and DONE.
REQ-017 SHALL, on accept of a non-shift op, register the result and go to DONE; out_valid high on the cycle after accept (latency 1).
REQ-018 SHALL, on accept of a shift op, load accumulator = SrcA and counter = SrcB[4:0]; counter 0 -> DONE directly (latency 1, result = SrcA); counter n>0 -> SHIFT.
REQ-019 SHALL, in SHIFT, shift accumulator by exactly one bit per cycle (SLL left zero-fill, SRL right zero-fill, SRA right sign-fill of current bit 31) and decrement counter; after the shift where counter was 1, go to DONE.
REQ-020 SHALL therefore assert out_valid exactly 1+n cycles after accept for a shift of n (n = 0..31).
REQ-021 SHALL latch the opcode and operands at accept; input changes after accept do not affect the result.
REQ-022 SHALL, in DONE, hold out_valid = 1 and ALUResult/Zero stable until out_valid && out_ready; on that cycle go to IDLE (out_valid low next cycle).
REQ-023 SHALL not accept a new request in the same cycle a result is consumed; earliest next accept is the cycle after consume (no overlap).
REQ-024 SHALL ignore out_ready in IDLE and SHIFT.
REQ-025 SHALL keep ALUResult at its last value outside DONE (not required to be meaningful while out_valid = 0); Zero always derived from ALUResult.

Reset
REQ-026 SHALL, when reset = 1 at a rising edge, go to IDLE, clear accumulator, counter and ALUResult to 0, out_valid = 0; Zero = 1 and in_ready = 1 from the following cycle.
REQ-027 SHALL give reset priority over accept, shift and consume in the same cycle; a reset in SHIFT or DONE discards the operation with no out_valid pulse.

Verification
REQ-028 SHALL cover: ADD SrcA=0x7FFFFFFF, SrcB=1 -> out_valid 1 cycle after accept, ALUResult=0x80000000, Zero=0; SUB 5-5 -> ALUResult=0, Zero=1.
REQ-029 SHALL cover: SRA SrcA=0x80000000, SrcB=0x0000001F -> out_valid 32 cycles after accept, ALUResult=0xFFFFFFFF; SRL same operands -> 0x00000001.
REQ-030 SHALL cover: SLL SrcA=0x1, SrcB=0xFFFFFFE0 (shamt 0) -> latency 1, ALUResult=0x1; SLT SrcA=0xFFFFFFFF, SrcB=1 -> 1; EQ 0x1234 vs 0x1234 -> 1.
REQ-031 SHALL cover: out_ready held 0 for 5 cycles in DONE -> out_valid and ALUResult stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-032 SHALL cover: reset asserted mid-SHIFT of a 20-bit SLL -> next cycle out_valid=0, in_ready=1, ALUResult=0; no result ever emitted for that request.
REQ-033 SHALL cover: Operation=1111 with any operands -> latency 1, ALUResult=0, Zero=1.
